logic_axi4_stream_packet_buffer_counter: RTL and testbench

//  Occupancy controller for the packet buffer queue. Snoops handshakes on the queue write side and read side.

---
 rtl/logic_axi4_stream_packet_buffer_counter_pkg.sv | 40 ++++
 rtl/logic_axi4_stream_if.sv | 13 +
 rtl/logic_axi4_stream_packet_buffer_counter_updown.sv | 64 ++++++
 rtl/logic_axi4_stream_packet_buffer_counter.sv | 127 ++++++++++++
 tb/tb_logic_axi4_stream_packet_buffer_counter.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/logic_axi4_stream_packet_buffer_counter_pkg.sv
// Shared types and arithmetic for the packet buffer occupancy counter.
// Optional macro LOGIC_AXI4_STREAM_PACKET_BUFFER_COUNTER_ERROR_EN turns on
// saturating counters with a sticky error flag. Without it, the counters wrap.
package logic_axi4_stream_packet_buffer_counter_pkg;

    typedef enum logic {
        FSM_ACTIVE = 1'b0,
        FSM_CLEAR  = 1'b1
    } fsm_t;

`ifdef LOGIC_AXI4_STREAM_PACKET_BUFFER_COUNTER_ERROR_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    // One counting step. Simultaneous inc and dec cancel out. With saturation,
    // a lone inc at max or a lone dec at zero is dropped. Without saturation,
    // the caller truncates to its width, so the result wraps.
    function automatic logic [31:0] next_count(
        input logic [31:0] cur,
        input logic        inc,
        input logic        dec,
        input logic [31:0] max
    );
        logic [31:0] res;
        res = cur;
        if (inc && !dec) begin
            if (!(SAT_EN && (cur == max))) begin
                res = cur + 32'd1;
            end
        end else if (dec && !inc) begin
            if (!(SAT_EN && (cur == 32'd0))) begin
                res = cur - 32'd1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/logic_axi4_stream_if.sv
// Minimal AXI4-Stream bundle: a monitor view for snooping handshakes
// and a transmit view for always-valid status words.
interface logic_axi4_stream_if #(
    parameter int DATA_WIDTH = 9
);
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [DATA_WIDTH-1:0] tdata;

    modport monitor (input tvalid, input tready, input tlast);
    modport tx      (output tvalid, output tdata, output tlast, input tready);
endinterface

// File: rtl/logic_axi4_stream_packet_buffer_counter_updown.sv
// Up/down counter with synchronous zeroing and, when
// LOGIC_AXI4_STREAM_PACKET_BUFFER_COUNTER_ERROR_EN is defined, saturation
// plus a sticky error flag for dropped events.
module logic_axi4_stream_packet_buffer_counter_updown
    import logic_axi4_stream_packet_buffer_counter_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int MAX   = 256
) (
    input  logic             aclk,
    input  logic             areset_n,
    input  logic             i_zero,
    input  logic             i_err_clr,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_count,
    output logic             o_error
);
    localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MAX);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_next;

    assign w_count_next = WIDTH'(next_count(32'(r_count), i_inc, i_dec, 32'(MAX_COUNT)));

    // Count register: zeroing has priority over counting.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_count <= '0;
        end else if (i_zero) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

    assign o_count = r_count;

`ifdef LOGIC_AXI4_STREAM_PACKET_BUFFER_COUNTER_ERROR_EN
    logic r_error;
    logic w_ignored;

    assign w_ignored = (i_inc && !i_dec && (r_count == MAX_COUNT)) ||
                       (i_dec && !i_inc && (r_count == '0));

    // Sticky error: set by any dropped event, cleared on completed clear.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_error <= 1'b0;
        end else if (i_err_clr) begin
            r_error <= 1'b0;
        end else if (!i_zero && w_ignored) begin
            r_error <= 1'b1;
        end
    end

    assign o_error = r_error;
`else
    logic w_unused_err;
    assign w_unused_err = i_err_clr;
    assign o_error      = 1'b0;
`endif

endmodule

// File: rtl/logic_axi4_stream_packet_buffer_counter.sv
// Occupancy controller for the packet buffer queue: counts beats and
// tlast beats held in the queue by snooping both sides' handshakes, and
// publishes both counts as always-valid stream words.
// Optional macro LOGIC_AXI4_STREAM_PACKET_BUFFER_COUNTER_ERROR_EN enables
// saturation and the sticky error output; otherwise error is tied low.
module logic_axi4_stream_packet_buffer_counter
    import logic_axi4_stream_packet_buffer_counter_pkg::*;
#(
    parameter int CAPACITY       = 256,
    parameter int CAPACITY_WIDTH = (CAPACITY >= 2) ? $clog2(CAPACITY) : 1
) (
    input  logic                      aclk,
    input  logic                      areset_n,
    logic_axi4_stream_if.monitor      wr_mon,
    logic_axi4_stream_if.monitor      rd_mon,
    logic_axi4_stream_if.tx           packets,
    logic_axi4_stream_if.tx           transfers,
    input  logic                      clear,
    output logic                      clear_ack,
    output logic                      error
);
    localparam int CW = CAPACITY_WIDTH + 1;

    fsm_t          r_state;
    fsm_t          w_state_next;
    logic          r_clear_ack;
    logic          w_clear_ack_next;
    logic          r_valid;
    logic          w_zero;
    logic          w_err_clr;
    logic          w_wr;
    logic          w_rd;
    logic          w_wr_last;
    logic          w_rd_last;
    logic [CW-1:0] w_transfers;
    logic [CW-1:0] w_packets;
    logic          w_err_transfers;
    logic          w_err_packets;
    logic          w_unused_tready;

    assign w_wr      = wr_mon.tvalid && wr_mon.tready;
    assign w_rd      = rd_mon.tvalid && rd_mon.tready;
    assign w_wr_last = w_wr && wr_mon.tlast;
    assign w_rd_last = w_rd && rd_mon.tlast;

    // Clear sequencing. Counters read zero from the cycle after clear is seen
    // and stay zero until both monitored sides go idle.
    always_comb begin
        w_state_next     = r_state;
        w_clear_ack_next = 1'b0;
        w_zero           = 1'b0;
        w_err_clr        = 1'b0;
        case (r_state)
            FSM_ACTIVE: begin
                if (clear) begin
                    w_state_next = FSM_CLEAR;
                    w_zero       = 1'b1;
                end
            end
            FSM_CLEAR: begin
                w_zero = 1'b1;
                if (!wr_mon.tvalid && !rd_mon.tvalid) begin
                    w_state_next     = FSM_ACTIVE;
                    w_clear_ack_next = 1'b1;
                    w_err_clr        = 1'b1;
                end
            end
            default: begin
                w_state_next = FSM_ACTIVE;
            end
        endcase
    end

    // State, acknowledge pulse and output-valid registers.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_state     <= FSM_ACTIVE;
            r_clear_ack <= 1'b0;
            r_valid     <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_clear_ack <= w_clear_ack_next;
            r_valid     <= 1'b1;
        end
    end

    logic_axi4_stream_packet_buffer_counter_updown #(
        .WIDTH (CW),
        .MAX   (CAPACITY)
    ) u_transfers (
        .aclk      (aclk),
        .areset_n  (areset_n),
        .i_zero    (w_zero),
        .i_err_clr (w_err_clr),
        .i_inc     (w_wr),
        .i_dec     (w_rd),
        .o_count   (w_transfers),
        .o_error   (w_err_transfers)
    );

    logic_axi4_stream_packet_buffer_counter_updown #(
        .WIDTH (CW),
        .MAX   (CAPACITY)
    ) u_packets (
        .aclk      (aclk),
        .areset_n  (areset_n),
        .i_zero    (w_zero),
        .i_err_clr (w_err_clr),
        .i_inc     (w_wr_last),
        .i_dec     (w_rd_last),
        .o_count   (w_packets),
        .o_error   (w_err_packets)
    );

    // Status words are always-valid; the consumer's tready has no effect.
    assign transfers.tvalid = r_valid;
    assign transfers.tdata  = w_transfers;
    assign transfers.tlast  = 1'b1;
    assign packets.tvalid   = r_valid;
    assign packets.tdata    = w_packets;
    assign packets.tlast    = 1'b1;
    assign w_unused_tready  = transfers.tready ^ packets.tready;

    assign clear_ack = r_clear_ack;
    assign error     = w_err_transfers | w_err_packets;

endmodule

// File: tb/tb_logic_axi4_stream_packet_buffer_counter.sv
// Self-checking bench for the packet buffer occupancy counter.
module tb_logic_axi4_stream_packet_buffer_counter;

    localparam int CAP = 256;
    localparam int MOD = 512;
`ifdef LOGIC_AXI4_STREAM_PACKET_BUFFER_COUNTER_ERROR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic aclk;
    logic areset_n;
    logic clear;
    logic clear_ack;
    logic error;

    logic_axi4_stream_if #(.DATA_WIDTH(9)) wr_if ();
    logic_axi4_stream_if #(.DATA_WIDTH(9)) rd_if ();
    logic_axi4_stream_if #(.DATA_WIDTH(9)) pk_if ();
    logic_axi4_stream_if #(.DATA_WIDTH(9)) tr_if ();

    logic_axi4_stream_packet_buffer_counter #(.CAPACITY(CAP)) dut (
        .aclk      (aclk),
        .areset_n  (areset_n),
        .wr_mon    (wr_if),
        .rd_mon    (rd_if),
        .packets   (pk_if),
        .transfers (tr_if),
        .clear     (clear),
        .clear_ack (clear_ack),
        .error     (error)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: occupancy as plain integers.
    int  m_t, m_p;
    bit  m_valid, m_ack, m_err, m_clearing;

    function automatic int step_count(input int c, input bit up, input bit down, inout bit err);
        int r = c;
        if (up && !down) begin
            if (ERR_EN && c == CAP) err = 1'b1;
            else r = (c + 1) % MOD;
        end else if (down && !up) begin
            if (ERR_EN && c == 0) err = 1'b1;
            else r = (c + MOD - 1) % MOD;
        end
        return r;
    endfunction

    always @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            m_t = 0; m_p = 0; m_valid = 0; m_ack = 0; m_err = 0; m_clearing = 0;
        end else begin
            bit wr, rd;
            wr = wr_if.tvalid && wr_if.tready;
            rd = rd_if.tvalid && rd_if.tready;
            m_valid = 1'b1;
            m_ack   = 1'b0;
            if (!m_clearing) begin
                if (clear) begin
                    m_clearing = 1'b1; m_t = 0; m_p = 0;
                end else begin
                    m_t = step_count(m_t, wr, rd, m_err);
                    m_p = step_count(m_p, wr && wr_if.tlast, rd && rd_if.tlast, m_err);
                end
            end else begin
                m_t = 0; m_p = 0;
                if (!wr_if.tvalid && !rd_if.tvalid) begin
                    m_clearing = 1'b0; m_ack = 1'b1; m_err = 1'b0;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge aclk) begin
        check("transfers.tvalid", int'(tr_if.tvalid), int'(m_valid));
        check("packets.tvalid",   int'(pk_if.tvalid), int'(m_valid));
        check("transfers.tdata",  int'(tr_if.tdata),  m_t);
        check("packets.tdata",    int'(pk_if.tdata),  m_p);
        check("clear_ack",        int'(clear_ack),    int'(m_ack));
        check("error",            int'(error),        int'(m_err));
        if (m_p <= m_t)
            check("invariant_pk_le_tr", int'(pk_if.tdata <= tr_if.tdata), 1);
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge aclk); #1; end
    endtask

    task automatic idle_inputs();
        wr_if.tvalid = 0; wr_if.tready = 0; wr_if.tlast = 0;
        rd_if.tvalid = 0; rd_if.tready = 0; rd_if.tlast = 0;
        clear = 0;
    endtask

    task automatic do_clear();
        clear = 1; cyc(1); clear = 0;
        check("clr_t0", int'(tr_if.tdata), 0);
        check("clr_ack_lo", int'(clear_ack), 0);
        cyc(1);
        check("clr_ack_hi", int'(clear_ack), 1);
        check("clr_err0", int'(error), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        wr_if.tdata = '0; rd_if.tdata = '0;
        pk_if.tready = 1; tr_if.tready = 1;
        areset_n = 0;
        cyc(2);
        check("rst_tvalid", int'(tr_if.tvalid), 0);
        check("rst_tdata",  int'(tr_if.tdata),  0);
        cyc(1);
        areset_n = 1;
        // 1: idle after reset
        cyc(3);
        check("t1_tvalid", int'(tr_if.tvalid), 1);
        check("t1_pvalid", int'(pk_if.tvalid), 1);
        check("t1_tdata",  int'(tr_if.tdata),  0);
        check("t1_err",    int'(error),        0);

        // 2: one 4-beat packet
        wr_if.tvalid = 1; wr_if.tready = 1;
        for (int i = 0; i < 4; i++) begin
            wr_if.tlast = (i == 3);
            cyc(1);
            $display("t2 beat %0d transfers=%0d packets=%0d", i, tr_if.tdata, pk_if.tdata);
            check("t2_transfers", int'(tr_if.tdata), i + 1);
            check("t2_packets",   int'(pk_if.tdata), (i == 3) ? 1 : 0);
        end

        // 3: one more beat to reach 5, then 10 cycles of simultaneous wr and rd
        wr_if.tlast = 0;
        cyc(1);
        check("t3_start", int'(tr_if.tdata), 5);
        rd_if.tvalid = 1; rd_if.tready = 1;
        for (int i = 0; i < 10; i++) begin
            wr_if.tlast = (i == 0 || i == 3 || i == 4 || i == 6 || i == 9);
            rd_if.tlast = (i == 1 || i == 4 || i == 7);
            cyc(1);
            $display("t3 cycle %0d transfers=%0d packets=%0d", i, tr_if.tdata, pk_if.tdata);
        end
        idle_inputs();
        check("t3_transfers", int'(tr_if.tdata), 5);
        check("t3_packets",   int'(pk_if.tdata), 3);
        do_clear();

        // 4: fill to capacity, then one beat past it
        wr_if.tvalid = 1; wr_if.tready = 1;
        cyc(256);
        check("t4_full", int'(tr_if.tdata), 256);
        check("t4_err0", int'(error), 0);
        cyc(1);
        wr_if.tvalid = 0;
        check("t4_over", int'(tr_if.tdata), ERR_EN ? 256 : 257);
        check("t4_err",  int'(error), ERR_EN ? 1 : 0);
        $display("t4 over transfers=%0d error=%0d", tr_if.tdata, error);
        do_clear();

        // 5: read from empty
        rd_if.tvalid = 1; rd_if.tready = 1;
        cyc(1);
        idle_inputs();
        check("t5_under", int'(tr_if.tdata), ERR_EN ? 0 : 511);
        check("t5_err",   int'(error), ERR_EN ? 1 : 0);
        $display("t5 under transfers=%0d error=%0d", tr_if.tdata, error);

        // 6: clear while the write side stays valid
        clear = 1; wr_if.tvalid = 1; wr_if.tready = 1;
        cyc(1);
        clear = 0;
        check("t6_t0", int'(tr_if.tdata), 0);
        cyc(3);
        check("t6_t_hold", int'(tr_if.tdata), 0);
        check("t6_ack_lo", int'(clear_ack), 0);
        wr_if.tvalid = 0;
        cyc(1);
        check("t6_ack_hi", int'(clear_ack), 1);
        check("t6_err",    int'(error), 0);
        cyc(1);
        check("t6_ack_pulse", int'(clear_ack), 0);
        $display("t6 clear done transfers=%0d", tr_if.tdata);

        // clear held high re-enters the clear sequence repeatedly
        wr_if.tvalid = 1; wr_if.tready = 1; cyc(2); wr_if.tvalid = 0;
        clear = 1; cyc(5); clear = 0; cyc(2);

        // reset in the middle of a clear: no acknowledge
        wr_if.tvalid = 1; wr_if.tready = 1; cyc(3);
        clear = 1; cyc(1); clear = 0;
        #2 areset_n = 0;
        #1;
        check("rmc_valid", int'(tr_if.tvalid), 0);
        check("rmc_ack",   int'(clear_ack), 0);
        check("rmc_t",     int'(tr_if.tdata), 0);
        cyc(2);
        wr_if.tvalid = 0;
        areset_n = 1;
        cyc(3);
        check("rmc_ack_after", int'(clear_ack), 0);
        check("rmc_t_after",   int'(tr_if.tdata), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
